// File: rtl/wb_exc_ctrl_if.sv
// Bundle between the writeback stage, the CSR file and the front end for the WB exception/ertn controller.
// The slave modport is the controller side; the master modport is the surrounding pipeline/CSR side.
interface wb_exc_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_ex_in;
  logic [5:0]  wb_ecode_in;
  logic [8:0]  wb_esubcode_in;
  logic [31:0] wb_vaddr_in;
  logic        wb_ertn;
  logic [12:0] int_is;
  logic [12:0] int_lie;
  logic        crmd_ie;
  logic [31:0] csr_eentry_data;
  logic [31:0] csr_era_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_vaddr;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic        ertn_flush;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        commit_valid;

  modport slave (
    input  wb_valid, wb_pc, wb_ex_in, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
    input  int_is, int_lie, crmd_ie, csr_eentry_data, csr_era_pc,
    output ex_valid, ex_pc, ex_vaddr, ex_ecode, ex_esubcode, ertn_flush,
    output flush, redirect_valid, redirect_pc, commit_valid
  );

  modport master (
    output wb_valid, wb_pc, wb_ex_in, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
    output int_is, int_lie, crmd_ie, csr_eentry_data, csr_era_pc,
    input  ex_valid, ex_pc, ex_vaddr, ex_ecode, ex_esubcode, ertn_flush,
    input  flush, redirect_valid, redirect_pc, commit_valid
  );
endinterface

// File: rtl/wb_exc_ctrl.sv
// Writeback exception/interrupt/ertn commit controller: CSR event strobes, fetch redirect, squash window.
// Optional feature macro: WB_EXC_INT_EN (defined = interrupts are taken; undefined = exceptions and ertn only).
module wb_exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [5:0]  INT_ECODE    = 6'h00
) (
  input logic          clk,
  input logic          reset,
  wb_exc_ctrl_if.slave bus
);
  localparam int unsigned   CW       = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  state_e        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          typ_exc_r;
  logic [31:0]   pc_r, vaddr_r;
  logic [5:0]    ecode_r;
  logic [8:0]    esub_r;

  logic          int_take_s, hit_s, latch_s, ev_exc_s;
  logic [5:0]    ev_ecode_s;
  logic [8:0]    ev_esub_s;

  logic          ex_valid_s, ertn_flush_s, flush_s, redirect_valid_s, commit_valid_s;
  logic [31:0]   ex_pc_s, ex_vaddr_s, redirect_pc_s;
  logic [5:0]    ex_ecode_s;
  logic [8:0]    ex_esub_s;

`ifdef WB_EXC_INT_EN
  assign int_take_s = (|(bus.int_is & bus.int_lie)) & bus.crmd_ie;
`else
  logic unused_int_s;
  assign unused_int_s = ^{bus.int_is, bus.int_lie, bus.crmd_ie};
  assign int_take_s   = 1'b0;
`endif

  // Event arbitration: exception beats interrupt beats ertn.
  always_comb begin
    hit_s      = bus.wb_valid & (bus.wb_ex_in | int_take_s | bus.wb_ertn);
    ev_exc_s   = bus.wb_ex_in | int_take_s;
    ev_ecode_s = bus.wb_ex_in ? bus.wb_ecode_in : INT_ECODE;
    ev_esub_s  = bus.wb_ex_in ? bus.wb_esubcode_in : 9'h000;
  end

  // Next-state and drain-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          state_nxt_s = REDIRECT;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      end
      DRAIN: begin
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and latched event fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      typ_exc_r <= 1'b0;
      pc_r      <= 32'h0000_0000;
      vaddr_r   <= 32'h0000_0000;
      ecode_r   <= 6'h00;
      esub_r    <= 9'h000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        typ_exc_r <= ev_exc_s;
        pc_r      <= bus.wb_pc;
        vaddr_r   <= bus.wb_vaddr_in;
        ecode_r   <= ev_ecode_s;
        esub_r    <= ev_esub_s;
      end
    end
  end

  // Output decode; everything is silenced while reset is asserted.
  always_comb begin
    ex_valid_s       = 1'b0;
    ertn_flush_s     = 1'b0;
    flush_s          = 1'b0;
    redirect_valid_s = 1'b0;
    commit_valid_s   = 1'b0;
    ex_pc_s          = 32'h0000_0000;
    ex_vaddr_s       = 32'h0000_0000;
    redirect_pc_s    = 32'h0000_0000;
    ex_ecode_s       = 6'h00;
    ex_esub_s        = 9'h000;
    if (reset) begin
      flush_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: commit_valid_s = bus.wb_valid & ~hit_s;
        REDIRECT: begin
          flush_s          = 1'b1;
          redirect_valid_s = 1'b1;
          if (typ_exc_r) begin
            ex_valid_s    = 1'b1;
            ex_pc_s       = pc_r;
            ex_vaddr_s    = vaddr_r;
            ex_ecode_s    = ecode_r;
            ex_esub_s     = esub_r;
            redirect_pc_s = bus.csr_eentry_data;
          end else begin
            ertn_flush_s  = 1'b1;
            redirect_pc_s = bus.csr_era_pc;
          end
        end
        DRAIN:   flush_s = 1'b1;
        default: flush_s = 1'b0;
      endcase
    end
  end

  assign bus.ex_valid       = ex_valid_s;
  assign bus.ex_pc          = ex_pc_s;
  assign bus.ex_vaddr       = ex_vaddr_s;
  assign bus.ex_ecode       = ex_ecode_s;
  assign bus.ex_esubcode    = ex_esub_s;
  assign bus.ertn_flush     = ertn_flush_s;
  assign bus.flush          = flush_s;
  assign bus.redirect_valid = redirect_valid_s;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.commit_valid   = commit_valid_s;
endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Directed bench for wb_exc_ctrl: a FLUSH_CYCLES=3 instance and a FLUSH_CYCLES=1 instance share stimulus.
module tb_wb_exc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wb_exc_ctrl_if bus3();
  wb_exc_ctrl_if bus1();

  always #5 clk = ~clk;

  assign bus1.wb_valid        = bus3.wb_valid;
  assign bus1.wb_pc           = bus3.wb_pc;
  assign bus1.wb_ex_in        = bus3.wb_ex_in;
  assign bus1.wb_ecode_in     = bus3.wb_ecode_in;
  assign bus1.wb_esubcode_in  = bus3.wb_esubcode_in;
  assign bus1.wb_vaddr_in     = bus3.wb_vaddr_in;
  assign bus1.wb_ertn         = bus3.wb_ertn;
  assign bus1.int_is          = bus3.int_is;
  assign bus1.int_lie         = bus3.int_lie;
  assign bus1.crmd_ie         = bus3.crmd_ie;
  assign bus1.csr_eentry_data = bus3.csr_eentry_data;
  assign bus1.csr_era_pc      = bus3.csr_era_pc;

  wb_exc_ctrl #(.FLUSH_CYCLES(3), .INT_ECODE(6'h00)) dut (.clk(clk), .reset(reset), .bus(bus3));
  wb_exc_ctrl #(.FLUSH_CYCLES(1), .INT_ECODE(6'h00)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus3.wb_valid       = 1'b0;
    bus3.wb_pc          = 32'h0;
    bus3.wb_ex_in       = 1'b0;
    bus3.wb_ecode_in    = 6'h00;
    bus3.wb_esubcode_in = 9'h000;
    bus3.wb_vaddr_in    = 32'h0;
    bus3.wb_ertn        = 1'b0;
    bus3.int_is         = 13'h0;
    bus3.int_lie        = 13'h0;
    bus3.crmd_ie        = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); reset = 1'b1; bus3.wb_valid = 1'b1; bus3.wb_pc = 32'h1c00_0000; #1;
    checks++; if (bus3.commit_valid !== 1'b0) begin errors++; $display("FAIL rst_commit0: got %b exp 0", bus3.commit_valid); end
    checks++; if ({bus3.flush, bus3.ex_valid, bus3.redirect_valid, bus3.ertn_flush} !== 4'b0000) begin errors++; $display("FAIL rst_outs0: got %b exp 0000", {bus3.flush, bus3.ex_valid, bus3.redirect_valid, bus3.ertn_flush}); end
    cyc(); #1;
    checks++; if (bus3.commit_valid !== 1'b0) begin errors++; $display("FAIL rst_commit1: got %b exp 0", bus3.commit_valid); end
    checks++; if (bus3.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rpc: got %h exp 0", bus3.redirect_pc); end
    cyc(); reset = 1'b0; #1;
    checks++; if (bus3.commit_valid !== 1'b1) begin errors++; $display("FAIL plain_commit: got %b exp 1", bus3.commit_valid); end
    checks++; if (bus3.flush !== 1'b0) begin errors++; $display("FAIL plain_flush: got %b exp 0", bus3.flush); end
  endtask

  task automatic test_exception();
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.wb_ex_in = 1'b1; bus3.wb_ecode_in = 6'h09;
    bus3.wb_vaddr_in = 32'h1234_5671; bus3.wb_pc = 32'h1c00_0010; #1;
    checks++; if (bus3.commit_valid !== 1'b0) begin errors++; $display("FAIL exc_nocommit: got %b exp 0", bus3.commit_valid); end
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.wb_pc = 32'h1c00_0014; #1;
    checks++; if (bus3.ex_valid !== 1'b1) begin errors++; $display("FAIL exc_valid: got %b exp 1", bus3.ex_valid); end
    checks++; if (bus3.ex_ecode !== 6'h09) begin errors++; $display("FAIL exc_ecode: got %h exp 09", bus3.ex_ecode); end
    checks++; if (bus3.ex_vaddr !== 32'h1234_5671) begin errors++; $display("FAIL exc_vaddr: got %h exp 12345671", bus3.ex_vaddr); end
    checks++; if (bus3.ex_pc !== 32'h1c00_0010) begin errors++; $display("FAIL exc_pc: got %h exp 1c000010", bus3.ex_pc); end
    checks++; if (bus3.redirect_pc !== 32'h1c00_8000) begin errors++; $display("FAIL exc_rpc: got %h exp 1c008000", bus3.redirect_pc); end
    checks++; if ({bus3.redirect_valid, bus3.flush, bus3.commit_valid, bus3.ertn_flush} !== 4'b1100) begin errors++; $display("FAIL exc_strobes: got %b exp 1100", {bus3.redirect_valid, bus3.flush, bus3.commit_valid, bus3.ertn_flush}); end
    cyc(); #1;
    checks++; if ({bus3.flush, bus3.redirect_valid, bus3.ex_valid, bus3.commit_valid} !== 4'b1000) begin errors++; $display("FAIL exc_drain1: got %b exp 1000", {bus3.flush, bus3.redirect_valid, bus3.ex_valid, bus3.commit_valid}); end
    checks++; if ({bus3.ex_pc, bus3.ex_vaddr} !== 64'h0) begin errors++; $display("FAIL exc_fields_zero: got %h exp 0", {bus3.ex_pc, bus3.ex_vaddr}); end
    cyc(); #1;
    checks++; if (bus3.flush !== 1'b1) begin errors++; $display("FAIL exc_drain2: got %b exp 1", bus3.flush); end
    cyc(); #1;
    checks++; if ({bus3.flush, bus3.commit_valid} !== 2'b01) begin errors++; $display("FAIL exc_idle: got %b exp 01", {bus3.flush, bus3.commit_valid}); end
    cyc(); clr(); #1;
  endtask

  task automatic test_ertn();
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.wb_ertn = 1'b1; bus3.wb_pc = 32'h1c00_0030; #1;
    checks++; if (bus3.commit_valid !== 1'b0) begin errors++; $display("FAIL ertn_nocommit: got %b exp 0", bus3.commit_valid); end
    cyc(); #1;
    checks++; if (bus3.ertn_flush !== 1'b1) begin errors++; $display("FAIL ertn_flush: got %b exp 1", bus3.ertn_flush); end
    checks++; if (bus3.redirect_pc !== 32'h1c00_0044) begin errors++; $display("FAIL ertn_rpc: got %h exp 1c000044", bus3.redirect_pc); end
    checks++; if ({bus3.ex_valid, bus3.ex_pc, bus3.ex_ecode} !== 39'h0) begin errors++; $display("FAIL ertn_ex_zero: got %h exp 0", {bus3.ex_valid, bus3.ex_pc, bus3.ex_ecode}); end
    cyc(); #1;
    checks++; if ({bus3.commit_valid, bus3.ertn_flush, bus3.flush} !== 3'b001) begin errors++; $display("FAIL ertn_squash1: got %b exp 001", {bus3.commit_valid, bus3.ertn_flush, bus3.flush}); end
    cyc(); #1;
    checks++; if ({bus3.commit_valid, bus3.flush} !== 2'b01) begin errors++; $display("FAIL ertn_squash2: got %b exp 01", {bus3.commit_valid, bus3.flush}); end
    cyc(); clr(); #1;
    checks++; if (bus3.flush !== 1'b0) begin errors++; $display("FAIL ertn_end: got %b exp 0", bus3.flush); end
    cyc(); cyc();
  endtask

  task automatic test_int_prio();
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.int_is = 13'h800; bus3.int_lie = 13'h800; bus3.crmd_ie = 1'b0; #1;
    checks++; if (bus3.commit_valid !== 1'b1) begin errors++; $display("FAIL int_masked_commit: got %b exp 1", bus3.commit_valid); end
    bus3.crmd_ie = 1'b1; bus3.wb_ertn = 1'b1; bus3.wb_pc = 32'h1c00_0050; #1;
    checks++; if (bus3.commit_valid !== 1'b0) begin errors++; $display("FAIL int_nocommit: got %b exp 0", bus3.commit_valid); end
    cyc(); clr(); #1;
`ifdef WB_EXC_INT_EN
    checks++; if ({bus3.ex_valid, bus3.ertn_flush} !== 2'b10) begin errors++; $display("FAIL int_wins: got %b exp 10", {bus3.ex_valid, bus3.ertn_flush}); end
    checks++; if ({bus3.ex_ecode, bus3.ex_esubcode, bus3.ex_pc} !== {6'h00, 9'h000, 32'h1c00_0050}) begin errors++; $display("FAIL int_fields: got %h", {bus3.ex_ecode, bus3.ex_esubcode, bus3.ex_pc}); end
    checks++; if (bus3.redirect_pc !== 32'h1c00_8000) begin errors++; $display("FAIL int_rpc: got %h exp 1c008000", bus3.redirect_pc); end
`else
    checks++; if ({bus3.ex_valid, bus3.ertn_flush} !== 2'b01) begin errors++; $display("FAIL int_off_ertn: got %b exp 01", {bus3.ex_valid, bus3.ertn_flush}); end
    checks++; if (bus3.redirect_pc !== 32'h1c00_0044) begin errors++; $display("FAIL int_off_rpc: got %h exp 1c000044", bus3.redirect_pc); end
`endif
    cyc(); cyc(); cyc(); #1;
    checks++; if (bus3.flush !== 1'b0) begin errors++; $display("FAIL int_end: got %b exp 0", bus3.flush); end
  endtask

  task automatic test_back_to_back();
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.wb_ex_in = 1'b1; bus3.wb_ecode_in = 6'h0a; bus3.wb_esubcode_in = 9'h001;
    bus3.int_is = 13'h001; bus3.int_lie = 13'h001; bus3.crmd_ie = 1'b1; bus3.wb_pc = 32'h1c00_0060; #1;
    cyc(); clr(); #1;
    checks++; if ({bus3.ex_valid, bus3.ex_ecode, bus3.ex_esubcode} !== {1'b1, 6'h0a, 9'h001}) begin errors++; $display("FAIL b2b_first: got %h exp 1_0a_001", {bus3.ex_valid, bus3.ex_ecode, bus3.ex_esubcode}); end
    cyc(); cyc();
    cyc(); bus3.wb_valid = 1'b1; bus3.wb_ex_in = 1'b1; bus3.wb_ecode_in = 6'h08; bus3.wb_pc = 32'h1c00_0020; #1;
    checks++; if ({bus3.flush, bus3.commit_valid} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b exp 00", {bus3.flush, bus3.commit_valid}); end
    cyc(); clr(); #1;
    checks++; if ({bus3.ex_valid, bus3.ex_ecode, bus3.ex_pc} !== {1'b1, 6'h08, 32'h1c00_0020}) begin errors++; $display("FAIL b2b_second: got %h exp 1_08_1c000020", {bus3.ex_valid, bus3.ex_ecode, bus3.ex_pc}); end
    cyc(); cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    cyc(); clr(); bus3.wb_valid = 1'b1; bus3.wb_ex_in = 1'b1; bus3.wb_ecode_in = 6'h07; bus3.wb_pc = 32'h1c00_0070; #1;
    cyc(); clr(); #1;
    checks++; if ({bus1.flush, bus1.redirect_valid, bus1.ex_valid} !== 3'b111) begin errors++; $display("FAIL f1_redirect: got %b exp 111", {bus1.flush, bus1.redirect_valid, bus1.ex_valid}); end
    cyc(); #1;
    checks++; if (bus1.flush !== 1'b0) begin errors++; $display("FAIL f1_one_cycle: got %b exp 0", bus1.flush); end
    checks++; if (bus3.flush !== 1'b1) begin errors++; $display("FAIL mid_drain1: got %b exp 1", bus3.flush); end
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    checks++; if ({bus3.flush, bus3.redirect_valid, bus3.ex_valid} !== 3'b000) begin errors++; $display("FAIL mid_after: got %b exp 000", {bus3.flush, bus3.redirect_valid, bus3.ex_valid}); end
    cyc(); #1;
    checks++; if ({bus3.flush, bus3.redirect_valid} !== 2'b00) begin errors++; $display("FAIL mid_after2: got %b exp 00", {bus3.flush, bus3.redirect_valid}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    bus3.csr_eentry_data = 32'h1c00_8000;
    bus3.csr_era_pc      = 32'h1c00_0044;
    test_reset();
    test_exception();
    test_ertn();
    test_int_prio();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
